// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: round-robin, lock-capable arbiter sharing one data memory between two masters
module data_memory_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [DATA_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  lock0,
  input  logic                  lock1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);
  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] P0   = 2'd1;
  localparam logic [1:0] P1   = 2'd2;
  localparam logic [3:0] LOCK_LIM = 4'(MAX_LOCK - 1);
  logic [1:0]            owner_q, owner_d, win;
  logic                  last_q, last_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  own0, own1, cont, elig0, elig1;
  logic                  rvalid0_q, rvalid1_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;
  assign own0 = owner_q == P0;
  assign own1 = owner_q == P1;
  // the current owner is never eligible, so an unlocked master cannot win two edges in a row
  assign elig0 = req0 && !own0;
  assign elig1 = req1 && !own1;
  assign cont  = ((own0 && lock0 && req0) || (own1 && lock1 && req1)) && cnt_q < LOCK_LIM;
  always_comb begin
    win     = elig0 && elig1 ? (last_q ? P0 : P1) : elig0 ? P0 : elig1 ? P1 : NONE;
    owner_d = cont ? owner_q : win;
    cnt_d   = cont ? cnt_q + 4'd1 : 4'd0;
    last_d  = (!cont && win != NONE) ? (win == P1) : last_q;
  end
  assign gnt0           = own0;
  assign gnt1           = own1;
  assign mem_address    = own0 ? addr0 : own1 ? addr1 : '0;
  assign mem_write_data = own0 ? wdata0 : own1 ? wdata1 : '0;
  assign mem_write      = (own0 && we0) || (own1 && we1);
  assign mem_read       = (own0 && !we0) || (own1 && !we1);
  assign rvalid0        = rvalid0_q;
  assign rvalid1        = rvalid1_q;
  assign rdata0         = rdata0_q;
  assign rdata1         = rdata1_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q   <= NONE;
      last_q    <= 1'b1;
      cnt_q     <= 4'd0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= own0 && !we0;
      rvalid1_q <= own1 && !we1;
      if (own0 && !we0) rdata0_q <= mem_read_data;
      if (own1 && !we1) rdata1_q <= mem_read_data;
    end
  end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed self-checking bench with a small behavioural memory
module tb_data_memory_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_write, mem_read;
  logic [31:0] rdata0, rdata1, mem_address, mem_write_data, mem_read_data;
  logic [31:0] mem [256] = '{16: 32'hDEADBEEF, 48: 32'h11111111, default: 32'h0};
  int          n_checks = 0;
  int          n_errors = 0;

  data_memory_arbiter #(.DATA_WIDTH(32), .MAX_LOCK(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;
  assign mem_read_data = mem[mem_address[7:0]];
  always @(posedge clk) if (mem_write) mem[mem_address[7:0]] <= mem_write_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_rvalid0", rvalid0, 0);
    check("rst_rvalid1", rvalid1, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_memaddr", mem_address, 0);
    check("rst_memwr", mem_write, 0);
    check("rst_memrd", mem_read, 0);
    #10 reset = 1'b1;
    tick();
    // single read of 0x10
    req0 = 1; we0 = 0; addr0 = 32'h10;
    tick();
    check("rd_gnt0", gnt0, 1);
    check("rd_gnt1", gnt1, 0);
    check("rd_memrd", mem_read, 1);
    check("rd_memwr", mem_write, 0);
    check("rd_addr", mem_address, 32'h10);
    check("rd_rvalid_early", rvalid0, 0);
    req0 = 0;
    tick();
    check("rd_rvalid0", rvalid0, 1);
    check("rd_rdata0", rdata0, 32'hDEADBEEF);
    check("rd_gnt0_off", gnt0, 0);
    tick();
    check("rd_rvalid0_pulse", rvalid0, 0);
    check("rd_rdata0_hold", rdata0, 32'hDEADBEEF);
    // port 1 writes 0x20, port 0 reads it back
    req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h12345678;
    tick();
    check("wr_gnt1", gnt1, 1);
    check("wr_memwr", mem_write, 1);
    check("wr_memrd", mem_read, 0);
    check("wr_addr", mem_address, 32'h20);
    check("wr_wdata", mem_write_data, 32'h12345678);
    req1 = 0;
    tick();
    check("wr_no_rvalid1", rvalid1, 0);
    check("wr_committed", mem[32], 32'h12345678);
    we1 = 0;
    req0 = 1; addr0 = 32'h20;
    tick();
    check("wr_rd_gnt0", gnt0, 1);
    req0 = 0;
    tick();
    check("wr_rd_rvalid0", rvalid0, 1);
    check("wr_rd_rdata0", rdata0, 32'h12345678);
    tick();
    // contention: last served is P0, so P1 wins first, then strict alternation
    req0 = 1; req1 = 1; addr0 = 32'h10; addr1 = 32'h20;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("ct_gnt1_%0d", i), gnt1, (i % 2 == 0) ? 1 : 0);
      check($sformatf("ct_gnt0_%0d", i), gnt0, (i % 2 == 1) ? 1 : 0);
      check($sformatf("ct_rvalid1_%0d", i), rvalid1, (i % 2 == 1) ? 1 : 0);
      check($sformatf("ct_rvalid0_%0d", i), rvalid0, (i > 0 && i % 2 == 0) ? 1 : 0);
      check($sformatf("ct_memaddr_%0d", i), mem_address, (i % 2 == 0) ? 32'h20 : 32'h10);
    end
    check("ct_rdata1", rdata1, 32'h12345678);
    req0 = 0; req1 = 0;
    tick();
    tick();
    // lock bound with competitor: 4 gnt0 cycles, then P1
    req0 = 1; lock0 = 1;
    tick();
    check("lk_gnt0_1", gnt0, 1);
    req1 = 1;
    for (int i = 2; i <= 4; i++) begin
      tick();
      check($sformatf("lk_gnt0_%0d", i), gnt0, 1);
      check($sformatf("lk_gnt1_%0d", i), gnt1, 0);
    end
    tick();
    check("lk_rel_gnt0", gnt0, 0);
    check("lk_rel_gnt1", gnt1, 1);
    req1 = 0;
    tick();
    check("lk_back_gnt0", gnt0, 1);
    req0 = 0; lock0 = 0;
    tick();
    tick();
    // lock bound alone: 4 grants, one NONE cycle, then regranted
    req0 = 1; lock0 = 1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("la_gnt0_%0d", i), gnt0, 1);
    end
    tick();
    check("la_none_gnt0", gnt0, 0);
    check("la_none_gnt1", gnt1, 0);
    check("la_none_memrd", mem_read, 0);
    tick();
    check("la_regrant", gnt0, 1);
    // dropping req ends the lock
    req0 = 0;
    tick();
    check("ld_drop_gnt0", gnt0, 0);
    lock0 = 0;
    tick();
    // idle
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("id_gnt_%0d", i), {gnt0, gnt1}, 0);
      check($sformatf("id_mem_%0d", i), {mem_write, mem_read}, 0);
      check($sformatf("id_addr_%0d", i), mem_address, 0);
    end
    // reset mid-write: outputs drop at once, write never lands
    req0 = 1; we0 = 1; addr0 = 32'h30; wdata0 = 32'hAAAA5555;
    tick();
    check("mr_gnt0", gnt0, 1);
    check("mr_memwr", mem_write, 1);
    #2 reset = 1'b0;
    #1;
    check("mr_gnt0_drop", gnt0, 0);
    check("mr_memwr_drop", mem_write, 0);
    check("mr_rvalid0", rvalid0, 0);
    req0 = 0; we0 = 0;
    tick();
    check("mr_mem_unchanged", mem[48], 32'h11111111);
    check("mr_hold_gnt0", gnt0, 0);
    #2 reset = 1'b1;
    tick();
    check("mr_after_gnt0", gnt0, 0);
    check("mr_after_rvalid0", rvalid0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
